// File: rtl/id_ex_reg_pkg.sv
// Shared core pipeline package: control-field widths and the execute-stage
// control bundle with its bubble constant, used by decode and ID/EX logic.
package id_ex_reg_pkg;

  localparam int RESULT_SEC_W = 2;
  localparam int ALU_CTRL_W   = 4;
  localparam int IMM_SRC_W    = 3;
  localparam int FUNCT3_W     = 3;

  typedef logic [RESULT_SEC_W-1:0] result_sec_t;
  typedef logic [ALU_CTRL_W-1:0]   alu_ctrl_t;
  typedef logic [IMM_SRC_W-1:0]    imm_src_t;
  typedef logic [FUNCT3_W-1:0]     funct3_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        lui;
    logic        jal_r;
    result_sec_t result_sec;
    alu_ctrl_t   alu_control;
    funct3_t     funct3;
    logic        valid;
  } ex_ctrl_t;

  // A bubble carries no write enables and no redirect, so it has no side effect.
  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_reg_pipe_ff.sv
// Parameterised pipeline register with synchronous reset, clear and enable.
// Reset and clear both load CLR_VAL; clear wins over a deasserted enable.
module pipe_ff #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: non-blocking assignment so every pipeline flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) q <= CLR_VAL;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle capture of decode fields, stall hold,
// flush-to-bubble and a saturating count of inserted bubbles.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic                      i_Stall_E,
  input  logic                      i_Flush_E,
  input  logic                      i_RegWrite_D,
  input  logic                      i_MemWrite_D,
  input  logic                      i_Jump_D,
  input  logic                      i_Branch_D,
  input  logic                      i_ALUSrc_D,
  input  logic                      i_LUI_D,
  input  logic                      i_Jal_R,
  input  logic [RESULT_SEC_W-1:0]   i_ResultSec_D,
  input  logic [ALU_CTRL_W-1:0]     i_ALU_Control_D,
  input  logic [FUNCT3_W-1:0]       i_FUNCT3_D,
  input  logic [DATA_WIDTH-1:0]     i_RD1_D,
  input  logic [DATA_WIDTH-1:0]     i_RD2_D,
  input  logic [DATA_WIDTH-1:0]     i_ImmExt_D,
  input  logic [DATA_WIDTH-1:0]     i_PC_D,
  input  logic [DATA_WIDTH-1:0]     i_PCPlus4_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_Rs1_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_Rs2_D,
  input  logic [REG_ADDR_WIDTH-1:0] i_Rd_D,
  output logic                      o_RegWrite_E,
  output logic                      o_MemWrite_E,
  output logic                      o_Jump_E,
  output logic                      o_Branch_E,
  output logic                      o_ALUSrc_E,
  output logic                      o_LUI_E,
  output logic                      o_Jal_R,
  output logic [RESULT_SEC_W-1:0]   o_ResultSec_E,
  output logic [ALU_CTRL_W-1:0]     o_ALU_Control_E,
  output logic [FUNCT3_W-1:0]       o_FUNCT3_E,
  output logic [DATA_WIDTH-1:0]     o_RD1_E,
  output logic [DATA_WIDTH-1:0]     o_RD2_E,
  output logic [DATA_WIDTH-1:0]     o_ImmExt_E,
  output logic [DATA_WIDTH-1:0]     o_PC_E,
  output logic [DATA_WIDTH-1:0]     o_PCPlus4_E,
  output logic [REG_ADDR_WIDTH-1:0] o_Rs1_E,
  output logic [REG_ADDR_WIDTH-1:0] o_Rs2_E,
  output logic [REG_ADDR_WIDTH-1:0] o_Rd_E,
  output logic                      o_Valid_E,
  output logic [CNT_WIDTH-1:0]      o_Bubble_Cnt
);

  localparam int DATA_GRP_W = 5 * DATA_WIDTH;
  localparam int REG_GRP_W  = 3 * REG_ADDR_WIDTH;

  logic                  capture_en;
  ex_ctrl_t              ctrl_d, ctrl_q;
  logic [DATA_GRP_W-1:0] data_d, data_q;
  logic [REG_GRP_W-1:0]  regs_d, regs_q;

  assign capture_en = ~i_Stall_E;

  // Any instruction arriving from decode is real; only flush/reset make a bubble.
  assign ctrl_d = '{
    reg_write:   i_RegWrite_D,
    mem_write:   i_MemWrite_D,
    jump:        i_Jump_D,
    branch:      i_Branch_D,
    alu_src:     i_ALUSrc_D,
    lui:         i_LUI_D,
    jal_r:       i_Jal_R,
    result_sec:  i_ResultSec_D,
    alu_control: i_ALU_Control_D,
    funct3:      i_FUNCT3_D,
    valid:       1'b1
  };
  assign data_d = {i_RD1_D, i_RD2_D, i_ImmExt_D, i_PC_D, i_PCPlus4_D};
  assign regs_d = {i_Rs1_D, i_Rs2_D, i_Rd_D};

  pipe_ff #(.WIDTH($bits(ex_ctrl_t)), .CLR_VAL(BUBBLE_CTRL)) u_ctrl_ff (
    .clk(i_CLK), .rst(i_RST), .en(capture_en), .clr(i_Flush_E),
    .d(ctrl_d), .q(ctrl_q)
  );

  pipe_ff #(.WIDTH(DATA_GRP_W)) u_data_ff (
    .clk(i_CLK), .rst(i_RST), .en(capture_en), .clr(i_Flush_E),
    .d(data_d), .q(data_q)
  );

  pipe_ff #(.WIDTH(REG_GRP_W)) u_regs_ff (
    .clk(i_CLK), .rst(i_RST), .en(capture_en), .clr(i_Flush_E),
    .d(regs_d), .q(regs_q)
  );

  assign o_RegWrite_E    = ctrl_q.reg_write;
  assign o_MemWrite_E    = ctrl_q.mem_write;
  assign o_Jump_E        = ctrl_q.jump;
  assign o_Branch_E      = ctrl_q.branch;
  assign o_ALUSrc_E      = ctrl_q.alu_src;
  assign o_LUI_E         = ctrl_q.lui;
  assign o_Jal_R         = ctrl_q.jal_r;
  assign o_ResultSec_E   = ctrl_q.result_sec;
  assign o_ALU_Control_E = ctrl_q.alu_control;
  assign o_FUNCT3_E      = ctrl_q.funct3;
  assign o_Valid_E       = ctrl_q.valid;

  assign {o_RD1_E, o_RD2_E, o_ImmExt_E, o_PC_E, o_PCPlus4_E} = data_q;
  assign {o_Rs1_E, o_Rs2_E, o_Rd_E}                          = regs_q;

  // Saturating bubble counter; a stall leaves it untouched by construction.
  always_ff @(posedge i_CLK) begin
    if (i_RST)                                 o_Bubble_Cnt <= '0;
    else if (i_Flush_E && o_Bubble_Cnt != '1)  o_Bubble_Cnt <= o_Bubble_Cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: the driver pushes the expected stage state
// for each edge, an independent monitor pops and compares after the edge.
module tb_id_ex_reg;

  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int CW  = 4;

  typedef struct packed {
    logic          reg_write, mem_write, jump, branch, alu_src, lui, jal_r;
    logic [1:0]    result_sec;
    logic [3:0]    alu_control;
    logic [2:0]    funct3;
    logic [DW-1:0] rd1, rd2, imm, pc, pc4;
    logic [RAW-1:0] rs1, rs2, rd;
  } in_t;

  typedef struct packed {
    in_t          f;
    logic         valid;
    logic [CW-1:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0, stall = 1'b0, flush = 1'b0;
  in_t  din = '0;

  logic           o_reg_write, o_mem_write, o_jump, o_branch, o_alu_src, o_lui, o_jal_r;
  logic [1:0]     o_result_sec;
  logic [3:0]     o_alu_control;
  logic [2:0]     o_funct3;
  logic [DW-1:0]  o_rd1, o_rd2, o_imm, o_pc, o_pc4;
  logic [RAW-1:0] o_rs1, o_rs2, o_rd;
  logic           o_valid;
  logic [CW-1:0]  o_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Stall_E(stall), .i_Flush_E(flush),
    .i_RegWrite_D(din.reg_write), .i_MemWrite_D(din.mem_write), .i_Jump_D(din.jump),
    .i_Branch_D(din.branch), .i_ALUSrc_D(din.alu_src), .i_LUI_D(din.lui), .i_Jal_R(din.jal_r),
    .i_ResultSec_D(din.result_sec), .i_ALU_Control_D(din.alu_control), .i_FUNCT3_D(din.funct3),
    .i_RD1_D(din.rd1), .i_RD2_D(din.rd2), .i_ImmExt_D(din.imm), .i_PC_D(din.pc),
    .i_PCPlus4_D(din.pc4), .i_Rs1_D(din.rs1), .i_Rs2_D(din.rs2), .i_Rd_D(din.rd),
    .o_RegWrite_E(o_reg_write), .o_MemWrite_E(o_mem_write), .o_Jump_E(o_jump),
    .o_Branch_E(o_branch), .o_ALUSrc_E(o_alu_src), .o_LUI_E(o_lui), .o_Jal_R(o_jal_r),
    .o_ResultSec_E(o_result_sec), .o_ALU_Control_E(o_alu_control), .o_FUNCT3_E(o_funct3),
    .o_RD1_E(o_rd1), .o_RD2_E(o_rd2), .o_ImmExt_E(o_imm), .o_PC_E(o_pc),
    .o_PCPlus4_E(o_pc4), .o_Rs1_E(o_rs1), .o_Rs2_E(o_rs2), .o_Rd_E(o_rd),
    .o_Valid_E(o_valid), .o_Bubble_Cnt(o_cnt)
  );

  out_t  exp_q[$];
  string name_q[$];
  out_t  model = '0;
  int    total = 0;
  int    bad   = 0;

  // Distinct, non-trivial value in every field so swapped wiring shows up.
  function automatic in_t mk(input logic [31:0] s);
    in_t v;
    v.reg_write   = s[0];
    v.mem_write   = s[1];
    v.jump        = s[2];
    v.branch      = s[3];
    v.alu_src     = s[4];
    v.lui         = s[5];
    v.jal_r       = s[6];
    v.result_sec  = s[8:7];
    v.alu_control = s[12:9];
    v.funct3      = s[15:13];
    v.rd1         = s ^ 32'h1111_1111;
    v.rd2         = s ^ 32'h2222_2222;
    v.imm         = ~s;
    v.pc          = s << 2;
    v.pc4         = (s << 2) + 32'd4;
    v.rs1         = s[4:0];
    v.rs2         = s[9:5];
    v.rd          = s[14:10];
    return v;
  endfunction

  // Drive one cycle of stimulus and queue the state expected after its edge.
  task automatic step(input string name, input in_t d, input logic s, input logic f,
                      input logic r);
    @(negedge clk);
    din   = d;
    stall = s;
    flush = f;
    rst   = r;
    if (r) begin
      model = '0;
    end else if (f) begin
      model.f     = '0;
      model.valid = 1'b0;
      if (model.cnt != 4'hF) model.cnt = model.cnt + 4'd1;
    end else if (!s) begin
      model.f     = d;
      model.valid = 1'b1;
    end
    exp_q.push_back(model);
    name_q.push_back(name);
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (valid %b/%b cnt %0d/%0d)",
               name, act, exp, act.valid, exp.valid, act.cnt, exp.cnt);
    end
  endtask

  // Monitor: the stage presents a new state every edge; compare it #1 later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        out_t act;
        act.f = '{reg_write: o_reg_write, mem_write: o_mem_write, jump: o_jump,
                  branch: o_branch, alu_src: o_alu_src, lui: o_lui, jal_r: o_jal_r,
                  result_sec: o_result_sec, alu_control: o_alu_control,
                  funct3: o_funct3, rd1: o_rd1, rd2: o_rd2, imm: o_imm, pc: o_pc,
                  pc4: o_pc4, rs1: o_rs1, rs2: o_rs2, rd: o_rd};
        act.valid = o_valid;
        act.cnt   = o_cnt;
        check(name_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_t d;

    // Reset must ignore a fully populated input word, even with flush high.
    step("reset0", mk(32'hDEAD_BEEF), 1'b0, 1'b0, 1'b1);
    step("reset1", mk(32'hCAFE_F00D), 1'b0, 1'b1, 1'b1);

    // Plain pass-through of a minimal R-type-like word.
    d = '0;
    d.rd1 = 32'h0000_00A5;
    d.rd = 5'd5;
    d.reg_write = 1'b1;
    d.alu_control = 4'b0001;
    step("pass_a5", d, 1'b0, 1'b0, 1'b0);
    step("pass_pat1", mk(32'h1234_5678), 1'b0, 1'b0, 1'b0);
    step("pass_ones", mk(32'hFFFF_FFFF), 1'b0, 1'b0, 1'b0);
    step("pass_pat2", mk(32'hA5A5_5A5A), 1'b0, 1'b0, 1'b0);

    // Stall holds PC 0x100 for three edges, then 0x104 is taken.
    d = mk(32'h0000_7E01);
    d.pc = 32'h100;
    step("stall_cap", d, 1'b0, 1'b0, 1'b0);
    d.pc = 32'h104;
    d.rd1 = 32'h5555_0000;
    for (int i = 0; i < 3; i++) step("stall_hold", d, 1'b1, 1'b0, 1'b0);
    step("stall_rel", d, 1'b0, 1'b0, 1'b0);

    // Flush beats stall; a store must not survive.
    d = mk(32'h0000_00FF);
    d.mem_write = 1'b1;
    step("flush_over_stall", d, 1'b1, 1'b1, 1'b0);
    step("after_flush", mk(32'h0BAD_F00D), 1'b0, 1'b0, 1'b0);

    // Twenty back-to-back flushes: count saturates at 15 and holds.
    for (int i = 0; i < 20; i++)
      step("flush_sat", mk(32'h3000 + 32'(i)), 1'(i % 2), 1'b1, 1'b0);
    step("sat_pass", mk(32'h7654_3210), 1'b0, 1'b0, 1'b0);
    step("sat_stall", mk(32'h0F0F_0F0F), 1'b1, 1'b0, 1'b0);

    // Reset while stalled discards the held Rd=7 write.
    d = mk(32'h0000_0041);
    d.rd = 5'd7;
    d.reg_write = 1'b1;
    step("hold_rd7", d, 1'b0, 1'b0, 1'b0);
    step("hold_rd7_s", mk(32'h1111_0000), 1'b1, 1'b0, 1'b0);
    step("rst_in_stall", mk(32'h2222_0000), 1'b1, 1'b0, 1'b1);
    d = mk(32'h0000_2481);
    d.rd = 5'd9;
    step("post_rst_cap", d, 1'b0, 1'b0, 1'b0);
    step("post_rst_flush", mk(32'h4444_4444), 1'b0, 1'b1, 1'b0);
    step("post_rst_pass", mk(32'h8000_0001), 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
